// File: rtl/uart_packet_tx_pkg.sv
// Shared framing definitions for the robot serial link, used by both the
// packet transmitter and the receiver-side parser.
package uart_pkt_pkg;

   localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hAA;
   localparam int         FRAME_BYTES         = 7;
   localparam int         PAYLOAD_BYTES       = 5;
   localparam logic [2:0] LAST_BYTE_IDX       = 3'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } frame_state_e;

   // Position of each field within a frame; the parser relies on this order
   typedef enum logic [2:0] {
      FLD_HEADER = 3'd0,
      FLD_MOTION = 3'd1,
      FLD_X_HI   = 3'd2,
      FLD_X_LO   = 3'd3,
      FLD_Y_HI   = 3'd4,
      FLD_Y_LO   = 3'd5,
      FLD_CHK    = 3'd6
   } frame_field_e;

   typedef struct packed {
      logic [7:0]  motion;
      logic [15:0] lidarX;
      logic [15:0] lidarY;
   } payload_t;

   function automatic logic [7:0] payloadChecksum(input payload_t p);
      return p.motion ^ p.lidarX[15:8] ^ p.lidarX[7:0] ^ p.lidarY[15:8] ^ p.lidarY[7:0];
   endfunction

   function automatic logic [7:0] frameByte(input logic [2:0] idx, input payload_t p,
                                            input logic [7:0] header);
      logic [7:0] b;
      b = header;
      case (frame_field_e'(idx))
         FLD_HEADER: b = header;
         FLD_MOTION: b = p.motion;
         FLD_X_HI:   b = p.lidarX[15:8];
         FLD_X_LO:   b = p.lidarX[7:0];
         FLD_Y_HI:   b = p.lidarY[15:8];
         FLD_Y_LO:   b = p.lidarY[7:0];
         FLD_CHK:    b = payloadChecksum(p);
         default:    b = header;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// Request/payload/status bundle between the control logic and the packet
// transmitter; gpio_1 is the UART TXD pin.
interface uart_packet_tx_if;

   logic        send;
   logic [7:0]  motion_state;
   logic [15:0] lidar_x;
   logic [15:0] lidar_y;
   logic        busy;
   logic        frame_done;
   logic        gpio_1;

   modport master (
      output send, motion_state, lidar_x, lidar_y,
      input  busy, frame_done, gpio_1
   );

   modport slave (
      input  send, motion_state, lidar_x, lidar_y,
      output busy, frame_done, gpio_1
   );

endinterface

// File: rtl/uart_packet_tx_uart_tx.sv
// 8N1 serialiser, LSB first. A byte offered during the last cycle of the
// previous stop bit is taken immediately, so characters run back-to-back.
module uart_tx
   import uart_pkt_pkg::*;
#(
   parameter int CLK_HZ       = 50000000,
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_tx_en,
   input  logic [7:0] uart_tx_data,
   output logic       uart_tx_busy,
   output logic       uart_txd
);

   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int BAUD_W         = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam int STOP_POS       = PAYLOAD_BITS + 1;
   localparam int BIT_W          = $clog2(STOP_POS + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CYCLES_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  STOP_IDX      = BIT_W'(STOP_POS);
   localparam logic [BIT_W-1:0]  LAST_DATA_IDX = BIT_W'(PAYLOAD_BITS);

   logic              active_q;
   logic [BIT_W-1:0]  bitIdx_q;
   logic [BAUD_W-1:0] baud_q;
   logic [7:0]        shift_q;
   logic              txd_q;

   logic bitEnd;
   logic lastCycle;
   logic start;

   // Busy drops for the final stop-bit cycle so the next byte lands with no gap
   assign bitEnd       = (baud_q == BAUD_LAST);
   assign lastCycle    = active_q && bitEnd && (bitIdx_q == STOP_IDX);
   assign uart_tx_busy = active_q && !lastCycle;
   assign start        = uart_tx_en && !uart_tx_busy;
   assign uart_txd     = txd_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         active_q <= 1'b0;
         bitIdx_q <= '0;
         baud_q   <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
      end else if (start) begin
         active_q <= 1'b1;
         bitIdx_q <= '0;
         baud_q   <= '0;
         shift_q  <= uart_tx_data;
         txd_q    <= 1'b0;
      end else if (active_q) begin
         if (bitEnd) begin
            baud_q <= '0;
            if (bitIdx_q == STOP_IDX) begin
               active_q <= 1'b0;
               bitIdx_q <= '0;
               txd_q    <= 1'b1;
            end else begin
               bitIdx_q <= bitIdx_q + 1'b1;
               if (bitIdx_q == LAST_DATA_IDX) begin
                  txd_q <= 1'b1;
               end else begin
                  txd_q   <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
         end else begin
            baud_q <= baud_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_packet_tx.sv
// Packet framer: snapshots the payload on acceptance and streams
// header, payload and XOR check byte through the serialiser.
module uart_packet_tx
   import uart_pkt_pkg::*;
#(
   parameter int         CLK_HZ       = 50000000,
   parameter int         BIT_RATE     = 9600,
   parameter int         PAYLOAD_BITS = 8,
   parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER_BYTE
) (
   input  logic             clk,
   input  logic             rst,
   uart_packet_tx_if.slave  bus
);

   frame_state_e state_q;
   logic [2:0]   byteIdx_q;
   logic [2:0]   byteIdx_d;
   payload_t     snap_q;
   logic         busy_q;
   logic         frameDone_q;

   payload_t     payloadIn;
   logic         accept;
   logic         byteDone;
   logic         txEn;
   logic [7:0]   txData;
   logic         txBusy;
   logic         txd;

   assign payloadIn = '{motion: bus.motion_state, lidarX: bus.lidar_x, lidarY: bus.lidar_y};
   assign accept    = bus.send && !busy_q;
   assign byteDone  = (state_q == SEND) && !txBusy;
   assign byteIdx_d = byteIdx_q + 3'd1;

   // The header is constant, so it goes to the serialiser on the acceptance edge itself
   assign txEn   = accept || (byteDone && (byteIdx_q != LAST_BYTE_IDX));
   assign txData = accept ? HEADER_BYTE : frameByte(byteIdx_d, snap_q, HEADER_BYTE);

   assign bus.busy       = busy_q;
   assign bus.frame_done = frameDone_q;
   assign bus.gpio_1     = txd;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         byteIdx_q   <= '0;
         snap_q      <= '0;
         busy_q      <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         frameDone_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  snap_q    <= payloadIn;
                  byteIdx_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= SEND;
               end else begin
                  state_q   <= IDLE;
               end
            end
            SEND: begin
               if (byteDone) begin
                  if (byteIdx_q == LAST_BYTE_IDX) begin
                     byteIdx_q   <= '0;
                     busy_q      <= 1'b0;
                     frameDone_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     byteIdx_q   <= byteIdx_d;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   uart_tx #(
      .CLK_HZ       (CLK_HZ),
      .BIT_RATE     (BIT_RATE),
      .PAYLOAD_BITS (PAYLOAD_BITS)
   ) serialiser (
      .clk          (clk),
      .resetn       (~rst),
      .uart_tx_en   (txEn),
      .uart_tx_data (txData),
      .uart_tx_busy (txBusy),
      .uart_txd     (txd)
   );

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx at 10 clocks per bit: table of frames
// plus snapshot, back-to-back and mid-frame reset sequences.
module tb_uart_packet_tx;

   typedef struct {
      string       name;
      logic [7:0]  motion;
      logic [15:0] lidarX;
      logic [15:0] lidarY;
      logic [55:0] expBytes;
   } vec_t;

   localparam int NUM_VECS = 5;

   vec_t vecs [NUM_VECS];
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   uart_packet_tx_if bus();

   uart_packet_tx #(
      .CLK_HZ       (1000),
      .BIT_RATE     (100),
      .PAYLOAD_BITS (8),
      .HEADER_BYTE  (8'hAA)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] m, input logic [15:0] x, input logic [15:0] y);
      bus.motion_state = m;
      bus.lidar_x      = x;
      bus.lidar_y      = y;
   endtask

   task automatic pulseSend(input string tag);
      @(negedge clk);
      checkOutput({tag, ".readyBeforeSend"}, bus.busy, 1'b0);
      bus.send = 1'b1;
      @(posedge clk);
      #1 bus.send = 1'b0;
   endtask

   // Walks cycles 1..701 after the acceptance edge comparing every line sample
   task automatic captureFrame(input logic [55:0] expBytes, input bit injectMid, input string tag);
      int         lineErr;
      int         busyCnt;
      int         doneEarly;
      int         b;
      int         c;
      int         pos;
      int         off;
      logic       expLine;
      logic       firstLine;
      logic       doneLast;
      logic       busyLast;
      logic [7:0] byteV;
      logic [7:0] got [7];
      lineErr   = 0;
      busyCnt   = 0;
      doneEarly = 0;
      firstLine = 1'bx;
      doneLast  = 1'bx;
      busyLast  = 1'bx;
      for (int i = 0; i < 7; i++) got[i] = 8'h00;
      for (int k = 1; k <= 701; k++) begin
         @(negedge clk);
         if (k <= 700) begin
            b     = (k - 1) / 10;
            c     = b / 10;
            pos   = b % 10;
            off   = (k - 1) % 10;
            byteV = expBytes[55 - 8 * c -: 8];
            if (pos == 0)      expLine = 1'b0;
            else if (pos == 9) expLine = 1'b1;
            else               expLine = byteV[pos - 1];
            if (k == 1) firstLine = bus.gpio_1;
            if (bus.gpio_1 !== expLine) lineErr++;
            if (off == 5 && pos >= 1 && pos <= 8) got[c][pos - 1] = bus.gpio_1;
            if (bus.busy === 1'b1) busyCnt++;
            if (bus.frame_done !== 1'b0) doneEarly++;
         end else begin
            doneLast = bus.frame_done;
            busyLast = bus.busy;
         end
         if (injectMid && k == 50) begin
            bus.lidar_x = 16'hFFFF;
            bus.send    = 1'b1;
         end
         if (injectMid && k == 51) bus.send = 1'b0;
      end
      checkOutput({tag, ".startBit"}, firstLine, 1'b0);
      for (int i = 0; i < 7; i++)
         checkOutput($sformatf("%s.byte%0d", tag, i), got[i], expBytes[55 - 8 * i -: 8]);
      checkOutput({tag, ".lineTiming"}, lineErr, 0);
      checkOutput({tag, ".busyCycles"}, busyCnt, 700);
      checkOutput({tag, ".doneEarly"}, doneEarly, 0);
      checkOutput({tag, ".donePulse"}, doneLast, 1'b1);
      checkOutput({tag, ".busyInDone"}, busyLast, 1'b0);
   endtask

   task automatic idleWatch(input string tag, input int n);
      int bad;
      bad = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.gpio_1 !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) bad++;
      end
      checkOutput(tag, bad, 0);
   endtask

   initial begin
      bus.send = 1'b0;
      applyStimulus(8'h00, 16'h0000, 16'h0000);

      vecs[0] = '{"basic",   8'h03, 16'h1234, 16'hABCD, 56'hAA_03_12_34_AB_CD_43};
      vecs[1] = '{"zeros",   8'h00, 16'h0000, 16'h0000, 56'hAA_00_00_00_00_00_00};
      vecs[2] = '{"ones",    8'hFF, 16'hFFFF, 16'hFFFF, 56'hAA_FF_FF_FF_FF_FF_FF};
      vecs[3] = '{"pattern", 8'h5A, 16'hA55A, 16'h0F0F, 56'hAA_5A_A5_5A_0F_0F_A5};
      vecs[4] = '{"mixed",   8'h81, 16'h0102, 16'h8040, 56'hAA_81_01_02_80_40_42};

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset.gpio_1", bus.gpio_1, 1'b1);
      checkOutput("reset.busy", bus.busy, 1'b0);
      checkOutput("reset.frame_done", bus.frame_done, 1'b0);
      rst = 1'b0;
      idleWatch("idleAfterReset", 20);

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].motion, vecs[i].lidarX, vecs[i].lidarY);
         pulseSend(vecs[i].name);
         captureFrame(vecs[i].expBytes, 1'b0, vecs[i].name);
         idleWatch({vecs[i].name, ".idleAfter"}, 5);
      end

      // Payload change plus a second send mid-frame must not disturb anything
      applyStimulus(vecs[0].motion, vecs[0].lidarX, vecs[0].lidarY);
      pulseSend("snapshot");
      captureFrame(vecs[0].expBytes, 1'b1, "snapshot");
      idleWatch("snapshot.noSecondFrame", 30);

      // send held high: each frame starts the cycle after frame_done
      applyStimulus(vecs[3].motion, vecs[3].lidarX, vecs[3].lidarY);
      @(negedge clk);
      bus.send = 1'b1;
      @(posedge clk);
      captureFrame(vecs[3].expBytes, 1'b0, "b2b0");
      captureFrame(vecs[3].expBytes, 1'b0, "b2b1");
      bus.send = 1'b0;
      idleWatch("b2b.idleAfter", 20);

      // Reset during byte 3 (0x34), sampled on its data bit 3 which is low
      applyStimulus(vecs[0].motion, vecs[0].lidarX, vecs[0].lidarY);
      pulseSend("midReset");
      repeat (350) @(negedge clk);
      checkOutput("midReset.lineBeforeReset", bus.gpio_1, 1'b0);
      checkOutput("midReset.busyBeforeReset", bus.busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midReset.gpio_1", bus.gpio_1, 1'b1);
      checkOutput("midReset.busy", bus.busy, 1'b0);
      checkOutput("midReset.frame_done", bus.frame_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idleWatch("midReset.idleAfter", 25);
      applyStimulus(vecs[4].motion, vecs[4].lidarX, vecs[4].lidarY);
      pulseSend("afterReset");
      captureFrame(vecs[4].expBytes, 1'b0, "afterReset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
